// File: rtl/regfile_pkg.sv
// Shared types and helpers for the regfile_sb register file.
package regfile_pkg;

  typedef enum logic {
    INIT,
    READY
  } rf_state_t;

  localparam int unsigned REG_ZERO = 0;

  function automatic logic addr_is_zero(input logic [31:0] addr);
    return addr == 32'(REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_sb_rdport.sv
// One combinational read port: x0/INIT masking and optional write-through forwarding.
// Optional feature: REGFILE_BYPASS_EN (same-cycle writeback forwarding).
module regfile_sb_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            ready,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] reg_data,
  input  logic            reg_busy,
`ifdef REGFILE_BYPASS_EN
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
`endif
  output logic [XLEN-1:0] data,
  output logic            busy
);

  always_comb begin
    data = '0;
    busy = 1'b0;
    if (ready && !addr_is_zero(32'(addr))) begin
      data = reg_data;
      busy = reg_busy;
`ifdef REGFILE_BYPASS_EN
      // A same-cycle re-issue of the written register keeps it busy.
      if (wr_en && !addr_is_zero(32'(wr_addr)) && (addr == wr_addr)) begin
        data = wr_data;
        busy = iss_en && (iss_addr == wr_addr);
      end
`endif
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with busy scoreboard and post-reset clear sweep.
// Optional feature: REGFILE_BYPASS_EN (forwarding in the read ports).
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned NREGS = 32,
  parameter  int unsigned NRD   = 2,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_done,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data
);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  rf_state_t        state, state_d;
  logic [AW-1:0]    cnt;
  logic             ready;
  logic             sweep_last;
  logic             wr_ok, iss_ok;

  assign ready      = (state == READY);
  assign sweep_last = (cnt == AW'(NREGS - 1));
  assign wr_ok      = ready && wr_en && !addr_is_zero(32'(wr_addr));
  assign iss_ok     = ready && iss_en && !addr_is_zero(32'(iss_addr));

  always_comb begin
    state_d = state;
    case (state)
      INIT:    if (sweep_last) state_d = READY;
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      cnt       <= AW'(1);
      init_done <= 1'b0;
    end else begin
      state     <= state_d;
      init_done <= (state_d == READY);
      if (state == INIT) cnt <= cnt + AW'(1);
    end
  end

  // Storage has no reset; the sweep clears it one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) regs[cnt] <= '0;
      else if (wr_ok)    regs[wr_addr] <= wr_data;
    end
  end

  // Issue is applied after writeback so a same-cycle issue leaves the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wr_ok)  busy[wr_addr]  <= 1'b0;
      if (iss_ok) busy[iss_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[k*AW +: AW];

    regfile_sb_rdport #(
      .XLEN(XLEN),
      .AW  (AW)
    ) u_rdport (
      .ready   (ready),
      .addr    (a),
      .reg_data(regs[a]),
      .reg_busy(busy[a]),
`ifdef REGFILE_BYPASS_EN
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .iss_en  (iss_en),
      .iss_addr(iss_addr),
`endif
      .data    (rd_data[k*XLEN +: XLEN]),
      .busy    (rd_busy[k])
    );
  end

endmodule
